// File: rtl/unidade_busca_pc_pkg.sv
// unidade_busca_pc_pkg: fetch-stage state encodings, shared opcodes and branch offset helper
package unidade_busca_pc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_BUBBLE, ST_HALT} state_t;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_BNE   = 7'b1100011;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    // B-type immediate carries offset bits 12:1; bit 0 is always zero
    function automatic logic [31:0] sext_b(input logic [11:0] imm);
        return {{19{imm[11]}}, imm, 1'b0};
    endfunction
endpackage

// File: rtl/unidade_busca_pc_if.sv
// unidade_busca_pc_if: control inputs and fetch status outputs of the fetch stage
interface unidade_busca_pc_if;
    logic        habilita;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [11:0] imediato;
    logic [31:0] pc;
    logic [31:0] endereco;
    logic        valid;
    logic        halted;
    logic        erro;
    modport master(output habilita, stall, branch_taken, branch_pc, imediato,
                   input pc, endereco, valid, halted, erro);
    modport slave(input habilita, stall, branch_taken, branch_pc, imediato,
                  output pc, endereco, valid, halted, erro);
endinterface

// File: rtl/calc_alvo_desvio.sv
// calc_alvo_desvio: BNE target address and legality (alignment and instruction memory range)
module calc_alvo_desvio
    import unidade_busca_pc_pkg::*;
#(
    parameter int NUM_INSTR = 3
) (
    input  logic [31:0] branch_pc_i,
    input  logic [11:0] imediato_i,
    output logic [31:0] alvo_o,
    output logic        alvo_invalido_o
);
    assign alvo_o = branch_pc_i + sext_b(imediato_i);
    assign alvo_invalido_o = (alvo_o[1:0] != 2'b00) || ((alvo_o >> 2) >= 32'(NUM_INSTR));
endmodule

// File: rtl/unidade_busca_pc.sv
// unidade_busca_pc: fetch stage owning the PC; linear fetch, stall hold, BNE redirect with bubble, halt
module unidade_busca_pc
    import unidade_busca_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          NUM_INSTR = 3
) (
    input logic               clock,
    input logic               reset,
    unidade_busca_pc_if.slave busca
);
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, alvo, pc_inc;
    logic        valid_q, valid_d, halted_q, halted_d, erro_q, erro_d;
    logic        alvo_inv, fim;

    calc_alvo_desvio #(.NUM_INSTR(NUM_INSTR)) u_alvo (
        .branch_pc_i    (busca.branch_pc),
        .imediato_i     (busca.imediato),
        .alvo_o         (alvo),
        .alvo_invalido_o(alvo_inv)
    );

    assign pc_inc = pc_q + 32'd4;
    assign fim    = (pc_inc >> 2) >= 32'(NUM_INSTR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = busca.habilita ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_d = busca.branch_taken ? (alvo_inv ? ST_HALT : ST_BUBBLE) :
                                 busca.stall ? ST_FETCH : fim ? ST_HALT : ST_FETCH;
            ST_BUBBLE: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A taken branch outranks stall; an illegal target halts with the PC left on the branch
    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        erro_d   = erro_q;
        case (state_q)
            ST_IDLE:   valid_d = busca.habilita;
            ST_FETCH: begin
                if (busca.branch_taken) begin
                    valid_d  = 1'b0;
                    pc_d     = alvo_inv ? pc_q : alvo;
                    halted_d = alvo_inv;
                    erro_d   = alvo_inv;
                end else if (!busca.stall) begin
                    valid_d  = !fim;
                    halted_d = fim;
                    pc_d     = fim ? pc_q : pc_inc;
                end
            end
            ST_BUBBLE: valid_d = 1'b1;
            ST_HALT:   ;
            default: begin
                pc_d     = RESET_PC;
                valid_d  = 1'b0;
                halted_d = 1'b0;
                erro_d   = 1'b0;
            end
        endcase
    end

    assign busca.pc       = pc_q;
    assign busca.endereco = pc_q >> 2;
    assign busca.valid    = valid_q;
    assign busca.halted   = halted_q;
    assign busca.erro     = erro_q;
endmodule

// File: tb/tb_unidade_busca_pc.sv
// tb_unidade_busca_pc: directed fetch scenarios plus randomized stimulus against a behavioural fetch model
module tb_unidade_busca_pc;
    localparam int NI = 3;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    unidade_busca_pc_if busca();
    unidade_busca_pc #(.RESET_PC(32'h0), .NUM_INSTR(NI)) dut (
        .clock(clock),
        .reset(reset),
        .busca(busca)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit          m_run, m_bub, m_halt, m_err, m_valid;
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_bub = 0; m_halt = 0; m_err = 0; m_valid = 0; m_pc = 32'h0;
    endtask

    // Model: one clock edge of the fetch stage, written from the behavioural rules
    task automatic m_step();
        int          off;
        logic [31:0] t;
        if (m_halt) begin
        end else if (!m_run) begin
            if (busca.habilita) begin m_run = 1; m_valid = 1; end
        end else if (m_bub) begin
            m_bub = 0; m_valid = 1;
        end else if (busca.branch_taken) begin
            off = busca.imediato[11] ? (int'(busca.imediato) - 4096) * 2 : int'(busca.imediato) * 2;
            t = busca.branch_pc + 32'(off);
            m_valid = 0;
            if ((t % 4) != 0 || (t / 4) >= NI) begin m_halt = 1; m_err = 1; end
            else begin m_pc = t; m_bub = 1; end
        end else if (!busca.stall) begin
            if ((m_pc + 4) / 4 >= NI) begin m_halt = 1; m_valid = 0; end
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic chk_all(input string ph);
        chk({ph, ".pc"}, busca.pc, m_pc);
        chk({ph, ".endereco"}, busca.endereco, m_pc / 4);
        chk({ph, ".valid"}, 32'(busca.valid), 32'(m_valid));
        chk({ph, ".halted"}, 32'(busca.halted), 32'(m_halt));
        chk({ph, ".erro"}, 32'(busca.erro), 32'(m_err));
    endtask

    task automatic drive(input bit hab, input bit st, input bit bt, input logic [31:0] bpc, input logic [11:0] imm);
        busca.habilita = hab; busca.stall = st; busca.branch_taken = bt;
        busca.branch_pc = bpc; busca.imediato = imm;
    endtask

    task automatic step(input string ph);
        @(posedge clock);
        if (!reset) m_reset(); else m_step();
        #1;
        chk_all(ph);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        step("rst");
        reset = 1'b1;
    endtask

    task automatic async_rst(input string ph);
        #3;
        reset = 1'b0;
        m_reset();
        #1;
        chk_all(ph);
        chk({ph, ".pc0"}, busca.pc, 32'h0);
        chk({ph, ".halted0"}, 32'(busca.halted), 32'd0);
        step(ph);
        reset = 1'b1;
    endtask

    initial begin
        m_reset();
        drive(0, 0, 0, 0, 0);
        step("rst1");
        step("rst2");
        chk("rst.valid", 32'(busca.valid), 32'd0);
        chk("rst.pc", busca.pc, 32'h0);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0);
        step("start");
        chk("start.valid", 32'(busca.valid), 32'd1);
        chk("start.endereco", busca.endereco, 32'd0);
        drive(0, 0, 0, 0, 0);
        step("lin1");
        chk("lin1.endereco", busca.endereco, 32'd1);
        step("lin2");
        chk("lin2.endereco", busca.endereco, 32'd2);
        step("lin_halt");
        chk("lin_halt.halted", 32'(busca.halted), 32'd1);
        chk("lin_halt.valid", 32'(busca.valid), 32'd0);
        chk("lin_halt.erro", 32'(busca.erro), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 32'h0, 12'h002);
            step("halt_hold");
            chk("halt_hold.pc", busca.pc, 32'd8);
        end

        drive(0, 0, 0, 0, 0);
        do_reset();
        drive(1, 0, 0, 0, 0);
        step("s_start");
        drive(0, 0, 0, 0, 0);
        step("s_adv");
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.pc", busca.pc, 32'd4);
            chk("stall.valid", 32'(busca.valid), 32'd1);
        end
        drive(0, 0, 0, 0, 0);
        step("unstall");
        chk("unstall.pc", busca.pc, 32'd8);
        drive(0, 1, 1, 32'd8, 12'hFFC);
        step("br");
        chk("br.pc", busca.pc, 32'd0);
        chk("br.valid", 32'(busca.valid), 32'd0);
        drive(0, 0, 0, 0, 0);
        step("bubble");
        chk("bubble.valid", 32'(busca.valid), 32'd1);
        chk("bubble.endereco", busca.endereco, 32'd0);

        do_reset();
        drive(1, 0, 0, 0, 0);
        step("m_start");
        drive(0, 0, 1, 32'd0, 12'h001);
        step("misal");
        chk("misal.erro", 32'(busca.erro), 32'd1);
        chk("misal.halted", 32'(busca.halted), 32'd1);
        chk("misal.pc", busca.pc, 32'd0);
        drive(0, 0, 0, 0, 0);
        do_reset();
        drive(1, 0, 0, 0, 0);
        step("r_start");
        drive(0, 0, 1, 32'd0, 12'h006);
        step("range");
        chk("range.erro", 32'(busca.erro), 32'd1);
        chk("range.halted", 32'(busca.halted), 32'd1);
        drive(0, 0, 0, 0, 0);
        async_rst("arst_halt");

        drive(1, 0, 0, 0, 0);
        step("b_start");
        drive(0, 0, 1, 32'd4, 12'hFFE);
        step("b_br");
        drive(0, 0, 0, 0, 0);
        async_rst("arst_bubble");

        for (int i = 0; i < 1500; i++) begin
            logic [11:0] imm;
            imm = $urandom_range(0, 1) ? 12'($urandom_range(0, 8)) : 12'hFFF - 12'($urandom_range(0, 8));
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                  32'($urandom_range(0, 12)), imm);
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                m_reset();
            end else begin
                reset = 1'b1;
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
